// File: rtl/axi4_slave_mem_responder_if.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem_responder_if
//   AXI4 (full) bus bundle between a master and axi4_slave_mem_responder.
//   The clock and reset are not part of the bundle; they stay plain ports.
//
//   Write address : S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
//                   S_AXI_AWBURST, S_AXI_AWVALID / S_AXI_AWREADY
//   Write data    : S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
//                   S_AXI_WVALID / S_AXI_WREADY
//   Write resp    : S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID / S_AXI_BREADY
//   Read address  : S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST,
//                   S_AXI_ARVALID / S_AXI_ARREADY
//   Read data     : S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
//                   S_AXI_RVALID / S_AXI_RREADY
// ---------------------------------------------------------------------------
interface axi4_slave_mem_responder_if;
    logic        S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;

    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;

    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;

    logic        S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;

    logic        S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_slave_mem_responder.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem_responder
//   AXI4 (full) slave backed by a 2**MEM_AWIDTH x 32-bit word memory.
//   Independent write and read FSMs share the memory; one outstanding
//   transaction per channel. INCR and FIXED bursts are served; WRAP and the
//   reserved burst type answer SLVERR (no writes, zero read data).
//   Programmable wait states: W_WAIT between W beats, R_LATENCY from AR to
//   first R beat, R_WAIT between R beats.
//
//   Ports:
//     ACLK    : clock
//     ARESET  : asynchronous, active-high reset (memory is not cleared)
//     s_axi   : AXI4 slave bundle (axi4_slave_mem_responder_if.slave)
// ---------------------------------------------------------------------------
module axi4_slave_mem_responder #(
    parameter int MEM_AWIDTH = 10,
    parameter int W_WAIT     = 0,
    parameter int R_LATENCY  = 1,
    parameter int R_WAIT     = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    axi4_slave_mem_responder_if.slave     s_axi
);

    localparam int DEPTH = 1 << MEM_AWIDTH;

    // Counters count down to zero, so the loaded value is one less than the
    // number of idle cycles wanted (W_WAIT idles are counted from the beat).
    localparam logic [3:0] W_WAIT_L = 4'(W_WAIT);
    localparam logic [3:0] R_LAT_L  = 4'(R_LATENCY - 1);
    localparam logic [3:0] R_WAIT_L = (R_WAIT > 0) ? 4'(R_WAIT - 1) : 4'd0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [MEM_AWIDTH-1:0] widx_t;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

    logic [31:0] mem [DEPTH];

    // ---------------- write channel ----------------
    wr_state_t   wr_state_q, wr_state_d;
    logic        awid_q;
    widx_t       waddr_q;
    logic [7:0]  awlen_q;
    logic [7:0]  wcnt_q;
    logic [3:0]  wwait_q;
    logic        w_bad_q;     // WRAP/reserved burst: whole burst refused
    logic        w_fixed_q;
    logic        w_err_q;     // WLAST disagreed with the beat count
    logic        aw_hs, w_hs, w_cnt_last, mem_we;
    logic        awready, wready, bvalid;

    assign w_cnt_last = (wcnt_q == awlen_q);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                awready = 1'b1;
                if (s_axi.S_AXI_AWVALID) begin
                    aw_hs      = 1'b1;
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (wwait_q == 4'd0) begin
                    wready = 1'b1;
                    if (s_axi.S_AXI_WVALID) begin
                        w_hs = 1'b1;
                        // Whichever comes first: the count or the master's WLAST.
                        if (w_cnt_last || s_axi.S_AXI_WLAST)
                            wr_state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (s_axi.S_AXI_BREADY)
                    wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    assign mem_we = w_hs & ~w_bad_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awid_q     <= 1'b0;
            waddr_q    <= '0;
            awlen_q    <= 8'd0;
            wcnt_q     <= 8'd0;
            wwait_q    <= 4'd0;
            w_bad_q    <= 1'b0;
            w_fixed_q  <= 1'b0;
            w_err_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) begin
                awid_q    <= s_axi.S_AXI_AWID;
                waddr_q   <= s_axi.S_AXI_AWADDR[MEM_AWIDTH+1:2];
                awlen_q   <= s_axi.S_AXI_AWLEN;
                w_bad_q   <= s_axi.S_AXI_AWBURST[1];
                w_fixed_q <= (s_axi.S_AXI_AWBURST == 2'b00);
                wcnt_q    <= 8'd0;
                wwait_q   <= 4'd0;
                w_err_q   <= 1'b0;
            end else if (wr_state_q == WR_DATA) begin
                if (w_hs) begin
                    wcnt_q  <= wcnt_q + 8'd1;
                    wwait_q <= W_WAIT_L;
                    if (!w_fixed_q)
                        waddr_q <= waddr_q + widx_t'(1);
                    if (s_axi.S_AXI_WLAST != w_cnt_last)
                        w_err_q <= 1'b1;
                end else if (wwait_q != 4'd0) begin
                    wwait_q <= wwait_q - 4'd1;
                end
            end
        end
    end

    // Byte-enabled write; a read sampled on the same edge sees the old word.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.S_AXI_WSTRB[b])
                    mem[waddr_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BID     = awid_q;
    assign s_axi.S_AXI_BRESP   = (w_bad_q || w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read channel ----------------
    rd_state_t   rd_state_q, rd_state_d;
    logic        arid_q;
    widx_t       raddr_q, raddr_adv, rd_addr;
    logic [7:0]  arlen_q;
    logic [7:0]  rcnt_q, rd_cnt;
    logic [3:0]  rlat_q;
    logic        r_bad_q;
    logic        r_fixed_q;
    logic [31:0] rdata_q;
    logic        rlast_q;
    logic [1:0]  rresp_q;
    logic        ar_hs, r_hs, r_load;
    logic        arready, rvalid;

    assign raddr_adv = r_fixed_q ? raddr_q : raddr_q + widx_t'(1);

    // With R_WAIT=0 the next beat is loaded on the handshake edge itself, so
    // the sample address/count must already be the advanced ones.
    assign rd_addr = (rd_state_q == RD_DATA) ? raddr_adv : raddr_q;
    assign rd_cnt  = (rd_state_q == RD_DATA) ? rcnt_q + 8'd1 : rcnt_q;

    always_comb begin
        rd_state_d = rd_state_q;
        ar_hs      = 1'b0;
        r_hs       = 1'b0;
        r_load     = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                arready = 1'b1;
                if (s_axi.S_AXI_ARVALID) begin
                    ar_hs      = 1'b1;
                    rd_state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rlat_q == 4'd0) begin
                    r_load     = 1'b1;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                rvalid = 1'b1;
                if (s_axi.S_AXI_RREADY) begin
                    r_hs = 1'b1;
                    if (rlast_q)
                        rd_state_d = RD_IDLE;
                    else if (R_WAIT == 0)
                        r_load = 1'b1;
                    else
                        rd_state_d = RD_WAIT;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arid_q     <= 1'b0;
            raddr_q    <= '0;
            arlen_q    <= 8'd0;
            rcnt_q     <= 8'd0;
            rlat_q     <= 4'd0;
            r_bad_q    <= 1'b0;
            r_fixed_q  <= 1'b0;
            rdata_q    <= 32'd0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            case (rd_state_q)
                RD_IDLE: begin
                    if (ar_hs) begin
                        arid_q    <= s_axi.S_AXI_ARID;
                        raddr_q   <= s_axi.S_AXI_ARADDR[MEM_AWIDTH+1:2];
                        arlen_q   <= s_axi.S_AXI_ARLEN;
                        r_bad_q   <= s_axi.S_AXI_ARBURST[1];
                        r_fixed_q <= (s_axi.S_AXI_ARBURST == 2'b00);
                        rcnt_q    <= 8'd0;
                        rlat_q    <= R_LAT_L;
                    end
                end
                RD_WAIT: begin
                    if (rlat_q != 4'd0)
                        rlat_q <= rlat_q - 4'd1;
                end
                RD_DATA: begin
                    if (r_hs && !rlast_q) begin
                        raddr_q <= raddr_adv;
                        rcnt_q  <= rcnt_q + 8'd1;
                        rlat_q  <= R_WAIT_L;
                    end
                end
                default: ;
            endcase
            if (r_load) begin
                rdata_q <= r_bad_q ? 32'd0 : mem[rd_addr];
                rlast_q <= (rd_cnt == arlen_q);
                rresp_q <= r_bad_q ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RID     = arid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    // Address bits outside the word index and AWSIZE carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, s_axi.S_AXI_AWSIZE,
                                s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_AWADDR[31:MEM_AWIDTH+2],
                                s_axi.S_AXI_ARADDR[1:0], s_axi.S_AXI_ARADDR[31:MEM_AWIDTH+2]};

endmodule
